// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response constants and byte-lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2
  } hsize_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_slv_state_e;

  // Little-endian byte-lane enables for a legal (aligned, size <= word) access.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] m;
    m = 4'b1111;
    if (size == SIZE_BYTE)      m = 4'b0001 << lane;
    else if (size == SIZE_HALF) m = lane[1] ? 4'b1100 : 4'b0011;
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
    return ((size == SIZE_HALF) && lane[0]) || ((size == SIZE_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array with byte-enable write port and asynchronous read.
// Latency: write commits on the clock edge; read is combinational from addr.
// Backpressure: none; always accepts a write when we=1.
// Ports: clk; we/be/wdata write controls; addr shared by read and write; rdata.
module ahb_sram_mem #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backing a word SRAM: byte/half/word access, fixed wait states, 2-cycle ERROR.
// Latency: data phase of 1 + WAIT_STATES cycles after the address phase; errors always take 2 cycles.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle; accepts only when HREADY=1.
// Ports: HCLK/HRESETn; AHB address-phase inputs (HSEL..HREADY), HWDATA; HRDATA, HREADYOUT, HRESP.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_DEPTH   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW   = $clog2(MEM_DEPTH);
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 2;

  ahb_slv_state_e state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [AW+1:0]  off_q;
  logic [2:0]     size_q;
  logic           write_q;
  logic           hreadyout_q, hresp_q;

  logic           accept, req_err;
  logic [31:0]    offset;
  logic           mem_we;
  logic [31:0]    mem_rdata;

  assign accept = HSEL & HREADY & HTRANS[1];
  assign offset = HADDR - BASE_ADDR;
  // Addresses below the base wrap to a large offset and fail the range check too.
  assign req_err = (HSIZE > SIZE_WORD) || misaligned(HSIZE, HADDR[1:0]) || ({1'b0, offset} >= SPAN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = ST_DATA;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new transfer may be taken here.
        if (accept) begin
          if (req_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      off_q       <= '0;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hreadyout_q <= !(state_nxt inside {ST_WAIT, ST_ERR1});
      hresp_q     <= (state_nxt inside {ST_ERR1, ST_ERR2}) ? RESP_ERROR : RESP_OKAY;
      if (accept && (state_nxt != ST_IDLE)) begin
        off_q   <= offset[AW+1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
    end
  end

  // DATA is only ever the final OKAY cycle, so its closing edge is the commit point.
  assign mem_we = (state == ST_DATA) && write_q;

  ahb_sram_mem #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (lane_mask(size_q, off_q[1:0])),
    .addr  (off_q[AW+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HRDATA    = ((state == ST_DATA) && !write_q) ? mem_rdata : 32'd0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;   // 0: zero-wait DUT, 1: three-wait DUT
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'd0;
  logic        hlock = 1'b0;
  logic [31:0] hwdata = '0;

  logic [31:0] hrdata0, hrdata1, hrdata_m;
  logic        hrdy0, hrdy1, hresp0, hresp1, hrdy_m, hresp_m;

  int vecs = 0;
  int errs = 0;

  // Reference memory keyed by {dut, word address}.
  logic [31:0] mdl [logic [30:0]];

  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hlock),
    .HREADY(hrdy0), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0));

  ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h0000_4000)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hlock),
    .HREADY(hrdy1), .HWDATA(hwdata), .HRDATA(hrdata1), .HREADYOUT(hrdy1), .HRESP(hresp1));

  assign hrdata_m = sel ? hrdata1 : hrdata0;
  assign hrdy_m   = sel ? hrdy1 : hrdy0;
  assign hresp_m  = sel ? hresp1 : hresp0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] key(input logic s, input logic [31:0] a);
    return {s, a[31:2]};
  endfunction

  // Error rule from the bus protocol: bad size, misaligned, or outside the window.
  function automatic logic model_err(input logic s, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] base, span, d;
    int nb;
    base = s ? 32'h4000 : 32'h0;
    span = s ? 32'd1024 : 32'd4096;
    d = a - base;
    nb = 1 << sz;
    return (sz > 3'd2) || ((a % nb) != 0) || (d >= span);
  endfunction

  task automatic model_write(input logic s, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int lane;
    w = mdl.exists(key(s, a)) ? mdl[key(s, a)] : 32'd0;
    for (int b = 0; b < (1 << sz); b++) begin
      lane = int'(a % 4) + b;
      w[lane*8 +: 8] = wd[lane*8 +: 8];
    end
    mdl[key(s, a)] = w;
  endtask

  // Single non-pipelined transfer; starts and ends just after a clock edge.
  task automatic xfer(input logic s, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits,
                      output logic resp_first, output logic resp_last);
    sel = s; hsel = 1'b1; htrans = 2'd2; hwrite = w; haddr = a; hsize = sz;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wd;
    waits = 0;
    resp_first = hresp_m;
    while (hrdy_m !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    resp_last = hresp_m;
    rd = hrdata_m;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic s, input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] rd;
    int wt;
    logic rf, rl, e;
    e = model_err(s, a, sz);
    xfer(s, w, a, sz, wd, rd, wt, rf, rl);
    if (e) begin
      chk("err_waits", 32'(wt), 32'd1);
      chk("err_resp1", {31'd0, rf}, 32'd1);
      chk("err_resp2", {31'd0, rl}, 32'd1);
    end else begin
      chk("ok_waits", 32'(wt), s ? 32'd3 : 32'd0);
      chk("ok_resp", {31'd0, rl}, 32'd0);
      if (w) model_write(s, a, sz, wd);
      else   chk("rdata", rd, mdl[key(s, a)]);
    end
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] rd;
    int wt, n;
    logic rf, rl;
    logic [31:0] ra, rdat;
    logic [2:0] rsz;
    logic rs, rw;
    int r;

    tbl[0]  = '{1'b0, 1'b1, 32'h20,   3'd2, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h21,   3'd0, 32'h0000_AA00, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h22,   3'd1, 32'h1234_0000, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h20,   3'd2, 32'h0,         1'b0, 32'h1234_AA00};
    tbl[4]  = '{1'b0, 1'b1, 32'h00,   3'd2, 32'hCAFE_F00D, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h02,   3'd2, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h00,   3'd3, 32'h1111_1111, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h1000, 3'd2, 32'h2222_2222, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h00,   3'd2, 32'h0,         1'b0, 32'hCAFE_F00D};
    tbl[9]  = '{1'b0, 1'b0, 32'h01,   3'd1, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h23,   3'd0, 32'h0,         1'b0, 32'h1234_AA00};
    tbl[11] = '{1'b1, 1'b1, 32'h4010, 3'd2, 32'h0102_0304, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h4010, 3'd2, 32'h0,         1'b0, 32'h0102_0304};
    tbl[13] = '{1'b1, 1'b1, 32'h4400, 3'd2, 32'h3333_3333, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 32'h3FFC, 3'd2, 32'h0,         1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 32'h4013, 3'd0, 32'hFF00_0000, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h4010, 3'd2, 32'h0,         1'b0, 32'hFF02_0304};

    // Reset values
    #12;
    chk("rst_ready0", {31'd0, hrdy0}, 32'd1);
    chk("rst_resp0",  {31'd0, hresp0}, 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ready1", {31'd0, hrdy1}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE and BUSY with HSEL=1 get zero-wait OKAY
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 2; t++) begin
        sel = d[0]; hsel = 1'b1; htrans = 2'(t);
        @(posedge clk); #1;
        chk("idle_ready", {31'd0, hrdy_m}, 32'd1);
        chk("idle_resp", {31'd0, hresp_m}, 32'd0);
      end
    end
    hsel = 1'b0; htrans = 2'd0;

    // Back-to-back write then read of the same word, zero wait states
    sel = 1'b0; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
    chk("b2b_wr_ready", {31'd0, hrdy_m}, 32'd1);
    chk("b2b_wr_resp", {31'd0, hresp_m}, 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    chk("b2b_rd_ready", {31'd0, hrdy_m}, 32'd1);
    chk("b2b_rd_resp", {31'd0, hresp_m}, 32'd0);
    chk("b2b_rd_data", hrdata_m, 32'hDEAD_BEEF);
    model_write(1'b0, 32'h10, 3'd2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    chk("idle_rdata", hrdata_m, 32'd0);

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, wt, rf, rl);
      if (tbl[i].err) begin
        chk($sformatf("tbl%0d_waits", i), 32'(wt), 32'd1);
        chk($sformatf("tbl%0d_resp1", i), {31'd0, rf}, 32'd1);
        chk($sformatf("tbl%0d_resp2", i), {31'd0, rl}, 32'd1);
      end else begin
        chk($sformatf("tbl%0d_waits", i), 32'(wt), tbl[i].s ? 32'd3 : 32'd0);
        chk($sformatf("tbl%0d_resp", i), {31'd0, rl}, 32'd0);
        if (tbl[i].w) model_write(tbl[i].s, tbl[i].a, tbl[i].sz, tbl[i].wd);
        else          chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      end
    end

    // Cancel in ERR2: master is IDLE, next cycle is plain OKAY/ready
    xfer(1'b0, 1'b0, 32'h06, 3'd2, 32'h0, rd, wt, rf, rl);
    chk("cancel_resp_err2", {31'd0, rl}, 32'd1);
    chk("cancel_resp", {31'd0, hresp_m}, 32'd0);
    chk("cancel_ready", {31'd0, hrdy_m}, 32'd1);
    chk("cancel_rdata", hrdata_m, 32'd0);

    // Reset in the middle of a waited write: no partial write
    sel = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h4010; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hDEAD_DEAD;
    chk("mid_ready_low", {31'd0, hrdy_m}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, hrdy1}, 32'd1);
    chk("mid_rst_resp", {31'd0, hresp1}, 32'd0);
    chk("mid_rst_rdata", hrdata1, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 32'h4010, 3'd2, 32'h0);

    // Random traffic against the reference model
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        do_op(s[0], 1'b1, (s[0] ? 32'h4100 : 32'h100) + 32'(i * 4), 3'd2, $urandom);
      end
    end
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r == 0)      ra = (rs ? 32'h4400 : 32'h1000) + 32'($urandom_range(0, 15));
      else if (r == 1) ra = (rs ? 32'h4000 : 32'h0) - 32'd1 - 32'($urandom_range(0, 7));
      else             ra = (rs ? 32'h4100 : 32'h100) + 32'($urandom_range(0, 63));
      rsz = ($urandom_range(0, 7) == 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_op(rs, rw, ra, rsz, $urandom);
    end

    // Wait states with a NONSEQ held during the waits
    sel = 1'b1; hsel = 1'b1; htrans = 2'd2; hwrite = 1'b0; haddr = 32'h4100; hsize = 3'd2;
    @(posedge clk); #1;
    haddr = 32'h4104;
    n = 0;
    while (hrdy_m !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ws_a_waits", 32'(n), 32'd3);
    chk("ws_a_data", hrdata_m, mdl[key(1'b1, 32'h4100)]);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    n = 0;
    while (hrdy_m !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ws_b_waits", 32'(n), 32'd3);
    chk("ws_b_data", hrdata_m, mdl[key(1'b1, 32'h4104)]);
    @(posedge clk); #1;
    rdat = hrdata_m;
    chk("ws_idle_rdata", rdat, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
